// File: rtl/sf_camera_writer.sv
// Pixel stream writer: drains 32-bit words from a ping-pong FIFO read side and
// serializes them LSB byte first as an 8-bit stream framed by vsync/hsync.
module sf_camera_writer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic [CNT_WIDTH-1:0] i_line_words,
  input  logic [CNT_WIDTH-1:0] i_line_count,
  input  logic [CNT_WIDTH-1:0] i_hblank,
  input  logic [CNT_WIDTH-1:0] i_vblank,
  input  logic                 i_clear,
  input  logic                 i_fifo_ready,
  output logic                 o_fifo_activate,
  output logic                 o_fifo_strobe,
  input  logic [31:0]          i_fifo_data,
  input  logic [23:0]          i_fifo_size,
  output logic                 o_vsync,
  output logic                 o_hsync,
  output logic [7:0]           o_pix_data,
  output logic                 o_frame_done,
  output logic                 o_underrun
);

  // state     | meaning
  // S_IDLE    | no frame; waits for enable and non-zero geometry
  // S_VBLANK  | vsync low, counting vertical blank
  // S_LINE_WAIT | vsync high, waiting for the first word of a line
  // S_LINE    | hsync high, one byte per cycle
  // S_HBLANK  | hsync low, counting horizontal blank
  typedef enum logic [2:0] {
    S_IDLE, S_VBLANK, S_LINE_WAIT, S_LINE, S_HBLANK
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] lw_cfg_q, lw_cfg_d;
  logic [CNT_WIDTH-1:0] lc_cfg_q, lc_cfg_d;
  logic [CNT_WIDTH-1:0] hb_cfg_q, hb_cfg_d;
  logic [CNT_WIDTH-1:0] tmr_q, tmr_d;
  logic [CNT_WIDTH-1:0] lines_q, lines_d;
  logic [CNT_WIDTH-1:0] words_q, words_d;
  logic [1:0]           bcnt_q, bcnt_d;
  logic [31:0]          sr_q, sr_d;
  logic                 fd_q, fd_d;
  logic                 ur_q, ur_d;
  logic                 own_q, own_d;
  logic                 pend_q, pend_d;
  logic [23:0]          size_q, size_d;
  logic [23:0]          wcnt_q, wcnt_d;

  logic                 strobe;
  logic                 ur_set;
  logic                 start;
  logic                 start_ok;
  logic                 avail;
  logic [CNT_WIDTH-1:0] vb_eff;
  logic [CNT_WIDTH-1:0] hb_eff;

  assign start_ok = i_enable && (i_line_words != '0) && (i_line_count != '0);
  assign vb_eff   = (i_vblank == '0) ? CNT_WIDTH'(1) : i_vblank;
  assign hb_eff   = (hb_cfg_q == '0) ? CNT_WIDTH'(1) : hb_cfg_q;
  // A word is presentable once the size is latched and the buffer is not drained.
  assign avail    = own_q && !pend_q && (wcnt_q != size_q);

  always_comb begin
    state_d  = state_q;
    lw_cfg_d = lw_cfg_q;
    lc_cfg_d = lc_cfg_q;
    hb_cfg_d = hb_cfg_q;
    tmr_d    = tmr_q;
    lines_d  = lines_q;
    words_d  = words_q;
    bcnt_d   = bcnt_q;
    sr_d     = sr_q;
    fd_d     = 1'b0;
    ur_set   = 1'b0;
    strobe   = 1'b0;
    start    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) start = 1'b1;
      end
      S_VBLANK: begin
        if (tmr_q > CNT_WIDTH'(1)) begin
          tmr_d = tmr_q - CNT_WIDTH'(1);
        end else begin
          lines_d = lc_cfg_q;
          state_d = S_LINE_WAIT;
        end
      end
      S_LINE_WAIT: begin
        if (avail) begin
          strobe  = 1'b1;
          sr_d    = i_fifo_data;
          bcnt_d  = 2'd0;
          words_d = lw_cfg_q;
          state_d = S_LINE;
        end
      end
      S_LINE: begin
        if (bcnt_q != 2'd3) begin
          sr_d   = {8'h00, sr_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
        end else begin
          bcnt_d = 2'd0;
          if (words_q <= CNT_WIDTH'(1)) begin
            sr_d    = '0;
            tmr_d   = hb_eff;
            state_d = S_HBLANK;
          end else begin
            words_d = words_q - CNT_WIDTH'(1);
            if (avail) begin
              strobe = 1'b1;
              sr_d   = i_fifo_data;
            end else begin
              // Missing word: emit four zero bytes so the line length stays exact.
              sr_d   = '0;
              ur_set = 1'b1;
            end
          end
        end
      end
      S_HBLANK: begin
        if (tmr_q > CNT_WIDTH'(1)) begin
          tmr_d = tmr_q - CNT_WIDTH'(1);
        end else if (lines_q > CNT_WIDTH'(1)) begin
          lines_d = lines_q - CNT_WIDTH'(1);
          if (avail) begin
            strobe  = 1'b1;
            sr_d    = i_fifo_data;
            bcnt_d  = 2'd0;
            words_d = lw_cfg_q;
            state_d = S_LINE;
          end else begin
            state_d = S_LINE_WAIT;
          end
        end else begin
          fd_d = 1'b1;
          if (start_ok) start = 1'b1;
          else          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      lw_cfg_d = i_line_words;
      lc_cfg_d = i_line_count;
      hb_cfg_d = i_hblank;
      tmr_d    = vb_eff;
      state_d  = S_VBLANK;
    end
  end

  always_comb begin
    own_d  = own_q;
    pend_d = 1'b0;
    size_d = size_q;
    wcnt_d = wcnt_q;
    if (!own_q) begin
      if (i_fifo_ready) begin
        own_d  = 1'b1;
        pend_d = 1'b1;
        wcnt_d = '0;
      end
    end else if (pend_q) begin
      size_d = i_fifo_size;
    end else if (wcnt_q == size_q) begin
      own_d = 1'b0;
    end else if (strobe) begin
      wcnt_d = wcnt_q + 24'd1;
    end
  end

  assign ur_d = ur_set | (ur_q & ~i_clear);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      lw_cfg_q <= '0;
      lc_cfg_q <= '0;
      hb_cfg_q <= '0;
      tmr_q    <= '0;
      lines_q  <= '0;
      words_q  <= '0;
      bcnt_q   <= '0;
      sr_q     <= '0;
      fd_q     <= 1'b0;
      ur_q     <= 1'b0;
      own_q    <= 1'b0;
      pend_q   <= 1'b0;
      size_q   <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      lw_cfg_q <= lw_cfg_d;
      lc_cfg_q <= lc_cfg_d;
      hb_cfg_q <= hb_cfg_d;
      tmr_q    <= tmr_d;
      lines_q  <= lines_d;
      words_q  <= words_d;
      bcnt_q   <= bcnt_d;
      sr_q     <= sr_d;
      fd_q     <= fd_d;
      ur_q     <= ur_d;
      own_q    <= own_d;
      pend_q   <= pend_d;
      size_q   <= size_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign o_fifo_activate = own_q;
  assign o_fifo_strobe   = strobe;
  assign o_vsync         = (state_q == S_LINE_WAIT) || (state_q == S_LINE) || (state_q == S_HBLANK);
  assign o_hsync         = (state_q == S_LINE);
  assign o_pix_data      = o_hsync ? sr_q[7:0] : 8'h00;
  assign o_frame_done    = fd_q;
  assign o_underrun      = ur_q;

endmodule

// File: doc/sf_camera_writer.md
Name: sf_camera_writer

Overview:
- Transmit-side counterpart of the camera capture path: drains 32-bit words from the read side of a ping-pong FIFO and serializes them as an 8-bit pixel stream framed by vsync/hsync.
- Used to feed a display/sensor-emulation port and as a loopback source for the camera capture block.
- Byte order matches the capture packing: bits [7:0] of each word go out first, bits [31:24] last.

Parameters:
- CNT_WIDTH, 16, width of line/blank/word counters and of the matching config inputs.

Ports:
- clk  input  1  single system clock; all logic and outputs are synchronous to it.
- rst  input  1  asynchronous, active-low reset.
- i_enable  input  1  level; start frames while high; a frame in progress always completes.
- i_line_words  input  CNT_WIDTH  32-bit words per line (bytes per line = 4*value); 0 = no frames start.
- i_line_count  input  CNT_WIDTH  lines per frame; 0 = no frames start.
- i_hblank  input  CNT_WIDTH  hsync-low cycles after each line (minimum 1 is enforced).
- i_vblank  input  CNT_WIDTH  vsync-low cycles before each frame (minimum 1 is enforced).
- i_clear  input  1  pulse; clears o_underrun.
- i_fifo_ready  input  1  a filled FIFO buffer is available.
- o_fifo_activate  output  1  owns a read buffer.
- o_fifo_strobe  output  1  pops the current word, one-cycle pulse.
- i_fifo_data  input  32  current word; valid one cycle after activate rises and one cycle after each strobe.
- i_fifo_size  input  24  word count of the activated buffer; sampled on the cycle after activate rises.
- o_vsync  output  1  high for the whole active portion of a frame.
- o_hsync  output  1  high while line bytes are on o_pix_data.
- o_pix_data  output  8  pixel byte; 0x00 whenever o_hsync is low.
- o_frame_done  output  1  one-cycle pulse at the end of each frame.
- o_underrun  output  1  sticky; set when a byte was needed and no FIFO data existed.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; every output is 0; all counters cleared; the FIFO buffer is released.
- Config inputs are latched on IDLE->VBLANK and held for the whole frame.
- States:
  - IDLE: enters VBLANK when i_enable=1 and i_line_words != 0 and i_line_count != 0.
  - VBLANK: vsync=0 for max(i_vblank,1) cycles, then goes to LINE_WAIT.
  - LINE_WAIT: vsync=1, hsync=0. Stays here until a word is loaded into the 32-bit shift register, then goes to LINE.
  - LINE: hsync=1 for exactly 4*line_words consecutive cycles, one byte per cycle.
  - HBLANK: hsync=0 for max(i_hblank,1) cycles. Then goes to LINE_WAIT if lines remain; otherwise pulses o_frame_done, drives vsync=0, and goes to VBLANK if i_enable=1, else IDLE.
- FIFO handling:
  - When no buffer is owned and i_fifo_ready=1: assert o_fifo_activate, latch i_fifo_size on the next cycle, and clear the per-buffer word count.
  - The shift register is loaded from i_fifo_data together with an o_fifo_strobe pulse. The next word is loaded during byte 3 of the current word, so the stream has no gaps.
  - When the word count reaches the latched size, drop o_fifo_activate; a new buffer may be acquired on the following cycle.
  - Lines may span buffers, and a buffer may span lines; leftover words carry over to the next line or frame.
  - A latched size of 0 releases the buffer immediately without issuing a strobe.
- Underrun: if LINE needs a new word and none is loaded, emit 0x00 for those 4 bytes, set o_underrun, and keep the line length exact. Resume normally once data is present.
- i_clear and an underrun in the same cycle: set wins.
- Deasserting i_enable mid-frame: the current frame finishes, o_frame_done pulses, then the block returns to IDLE.
- The owned buffer is not released when a frame ends.
- Counters saturate/compare at CNT_WIDTH; the word count is 24 bits. No wrap is reachable within legal config values.

Test Plan:
1. Reset mid-line (rst=0 during LINE) -> all outputs 0 immediately, o_fifo_activate=0; after release, nothing starts until i_enable=1.
2. line_words=2, line_count=2, hblank=3, vblank=4; one buffer of size 4 holding 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D -> 4 vsync-low cycles; then a line of bytes 01..08 with hsync high 8 cycles, 3 low, then 09..10; o_frame_done pulses once; exactly 4 strobes.
3. Buffer A of size 3 and buffer B of size 1; line_words=4, line_count=1 -> activate drops after the third strobe, B is acquired, 16 contiguous hsync-high bytes; o_underrun=0.
4. Only 1 word available, line_words=2 -> 4 data bytes, then 4 bytes of 0x00; hsync high for 8 cycles; o_underrun=1 and it stays set until i_clear.
5. i_clear and an underrun in the same cycle -> o_underrun=1.
6. i_enable dropped during line 1 of 3 -> all 3 lines are sent, o_frame_done pulses, the block returns to IDLE with vsync=0.
